// File: rtl/prt_read_scheduler.sv
// Purpose: round-robin arbiter sharing the PRT read port across NUM_REQ egress requesters, streaming each packet to its owner.
// Latency: ack is combinational in IDLE; first byte two cycles after ack; one IDLE cycle between back-to-back packets.
// Backpressure: any PRT RDY low stalls its state with EN low; out_ready low stalls the byte stream without consuming a byte.
module prt_read_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLOTS  = 4,
    parameter int NUM_REQ    = 2,
    parameter int MAX_BYTES  = 1518,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*SW-1:0]   req_slot,
    input  logic [NUM_REQ-1:0]      req_invalidate,
    output logic [NUM_REQ-1:0]      req_ack,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic [RW-1:0]           out_owner,
    output logic                    out_abort,
    output logic                    busy,
    output logic                    EN_start_reading_prt_entry,
    input  logic                    RDY_start_reading_prt_entry,
    output logic [SW-1:0]           start_reading_prt_entry_slot,
    output logic                    EN_read_prt_entry,
    input  logic                    RDY_read_prt_entry,
    input  logic [DATA_WIDTH:0]     read_prt_entry,
    output logic                    EN_invalidate_prt_entry,
    input  logic                    RDY_invalidate_prt_entry,
    output logic [SW-1:0]           invalidate_prt_entry_slot
);

    localparam logic [15:0] GUARD_CNT = 16'(MAX_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, READ, INVAL} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   owner;
    logic [RW-1:0]   rr_ptr;
    logic [SW-1:0]   slot;
    logic            inv;
    logic [15:0]     byte_cnt;

    logic [RW-1:0]   win;
    logic            win_vld;
    logic [SW-1:0]   win_slot;
    logic            win_inv;
    logic [RW-1:0]   idx_w;
    int              idx;
    logic            done_bit;
    logic            at_guard;

    // Round-robin pick: first requesting index after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = RW'(idx);
            if (!win_vld && req_valid[idx_w]) begin
                win_vld = 1'b1;
                win     = idx_w;
            end
        end
    end

    // Pull the winner's slot and invalidate flag out of the packed request buses.
    always_comb begin
        win_slot = '0;
        win_inv  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (RW'(i) == win) begin
                win_slot = req_slot[i*SW +: SW];
                win_inv  = req_invalidate[i];
            end
        end
    end

    assign done_bit = read_prt_entry[DATA_WIDTH];
    assign at_guard = (byte_cnt == GUARD_CNT);

    // Next-state and strobe generation; every EN is qualified by its RDY.
    always_comb begin
        state_nxt                  = state;
        req_ack                    = '0;
        EN_start_reading_prt_entry = 1'b0;
        EN_read_prt_entry          = 1'b0;
        EN_invalidate_prt_entry    = 1'b0;
        out_last                   = 1'b0;
        out_abort                  = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    req_ack[win] = 1'b1;
                    state_nxt    = START;
                end
            end
            START: begin
                EN_start_reading_prt_entry = RDY_start_reading_prt_entry;
                if (RDY_start_reading_prt_entry) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                EN_read_prt_entry = RDY_read_prt_entry && out_ready;
                out_last  = EN_read_prt_entry && (done_bit || at_guard);
                out_abort = EN_read_prt_entry && !done_bit && at_guard;
                if (out_last) begin
                    // A guard-aborted packet is always invalidated so the slot is reclaimed.
                    state_nxt = (inv || out_abort) ? INVAL : IDLE;
                end
            end
            INVAL: begin
                EN_invalidate_prt_entry = RDY_invalidate_prt_entry;
                if (RDY_invalidate_prt_entry) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid                    = EN_read_prt_entry;
    assign out_data                     = read_prt_entry[DATA_WIDTH-1:0];
    assign out_owner                    = owner;
    assign busy                         = (state != IDLE);
    assign start_reading_prt_entry_slot = slot;
    assign invalidate_prt_entry_slot    = slot;

    // State, grant context, byte counter and round-robin pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            owner    <= '0;
            slot     <= '0;
            inv      <= 1'b0;
            byte_cnt <= '0;
            rr_ptr   <= RW'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_vld) begin
                owner <= win;
                slot  <= win_slot;
                inv   <= win_inv;
            end
            if (EN_start_reading_prt_entry) begin
                byte_cnt <= '0;
            end else if (EN_read_prt_entry && byte_cnt != 16'hFFFF) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
            // Pointer moves only when a packet finishes, so the completed owner yields next.
            if (out_last) begin
                rr_ptr <= owner;
            end
        end
    end

endmodule

// File: doc/prt_read_scheduler.md
Name: prt_read_scheduler

Overview:
- Shares the single packet reference table (PRT) read port among NUM_REQ egress requesters.
- Grants requesters round-robin, sequences start_reading → byte stream → optional invalidate, and routes each streamed byte to the granted owner.
- Sits between the PRT and the egress/forwarding clients, alongside the master packet dealer, which owns the PRT write side.
- All PRT method strobes follow EN/RDY rules: an EN is never asserted without its RDY.

Parameters:
- DATA_WIDTH, 8, PRT payload byte width.
- NUM_SLOTS, 4, PRT slot count; SW = $clog2(NUM_SLOTS).
- NUM_REQ, 2, number of requesters (≥2); RW = $clog2(NUM_REQ).
- MAX_BYTES, 1518, guard length; a read is aborted if no done bit has arrived after this many bytes.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester read request, held until acked
- req_slot  in  NUM_REQ*SW  slot per requester, packed, requester i at [i*SW +: SW]
- req_invalidate  in  NUM_REQ  invalidate slot after read completes
- req_ack  out  NUM_REQ  one-cycle pulse: request i latched
- out_ready  in  1  sink can accept a byte this cycle
- out_valid  out  1  byte transferred this cycle
- out_data  out  DATA_WIDTH  byte
- out_last  out  1  final byte of packet, natural or aborted
- out_owner  out  RW  requester owning current stream
- out_abort  out  1  pulse with out_last when the MAX_BYTES guard fires
- busy  out  1  state != IDLE
- EN_start_reading_prt_entry  out  1
- RDY_start_reading_prt_entry  in  1
- start_reading_prt_entry_slot  out  SW  latched slot
- EN_read_prt_entry  out  1
- RDY_read_prt_entry  in  1
- read_prt_entry  in  DATA_WIDTH+1  [DATA_WIDTH] = done bit, low bits = byte; valid in the cycle EN&&RDY
- EN_invalidate_prt_entry  out  1
- RDY_invalidate_prt_entry  in  1
- invalidate_prt_entry_slot  out  SW  latched slot

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; all EN_*, req_ack, out_valid, out_last and out_abort = 0.
  - owner=0, slot=0, inv=0, byte_cnt=0, rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction drops it silently; no invalidate is issued.
- FSM states: IDLE, START, READ, INVAL.
- IDLE:
  - If any req_valid, the winner is the first set bit scanning from rr_ptr+1 with wrap.
  - Latch owner, req_slot[owner] and req_invalidate[owner]; req_ack[owner]=1 for that cycle; next state START.
  - No request → remain in IDLE.
- START:
  - EN_start_reading_prt_entry = RDY_start_reading_prt_entry.
  - Move to READ in the cycle EN=1; byte_cnt=0.
- READ:
  - EN_read_prt_entry = RDY_read_prt_entry && out_ready. This is combinational; out_valid equals EN_read_prt_entry.
  - out_data = read_prt_entry[DATA_WIDTH-1:0].
  - out_last = out_valid && (read_prt_entry[DATA_WIDTH] || byte_cnt == MAX_BYTES-1).
  - out_abort = out_valid && !read_prt_entry[DATA_WIDTH] && byte_cnt == MAX_BYTES-1.
  - Each transfer increments byte_cnt. byte_cnt is 16 bits and saturates; it never wraps.
  - On the out_last transfer: rr_ptr=owner; next state is INVAL if inv==1 or abort, otherwise IDLE.
  - An aborted packet is always invalidated.
- INVAL:
  - EN_invalidate_prt_entry = RDY_invalidate_prt_entry; invalidate_prt_entry_slot = latched slot.
  - Return to IDLE in the cycle EN=1.
- out_owner and the slot outputs hold their latched values outside IDLE; their value in IDLE is don't-care but stable.
- Latency:
  - Request to ack: 1 cycle (combinational in IDLE).
  - Ack to first byte: ≥2 cycles when the RDYs are high.
  - Back-to-back packets have 1 IDLE cycle between them.
- Simultaneous requests: exactly one ack per IDLE cycle.
- Requests changing while not in IDLE are ignored.
- A requester deasserting req_valid before ack loses its turn, with no side effect.
- RDY low in any state stalls that state with its EN low; there is no timeout except the byte guard.
- out_ready low stalls the stream with no byte consumed.

Test Plan:
- Single read: req_valid=01, slot[0]=2, inv=0; PRT returns 3 bytes 0xA1, 0xA2, 0x1A3 → req_ack=01 one cycle, start_slot=2, out_data A1/A2/A3 owner=0, out_last on A3, no EN_invalidate, back to IDLE.
- Round-robin: req_valid=11 held, each 1-byte packet → grants alternate 0,1,0,1; ack pulses never overlap.
- Invalidate: req 1, slot=3, inv=1 → after the last byte, EN_invalidate=1 with slot 3 for exactly one cycle once RDY_invalidate=1 (RDY held low 4 cycles → EN stays low those 4 cycles).
- Backpressure: out_ready toggles 1,0,1,0 during a 4-byte packet → EN_read only on ready cycles, bytes in order, none lost or duplicated.
- Guard abort: MAX_BYTES=4, PRT never sets the done bit → 4th byte has out_last=1 and out_abort=1; invalidate is issued even with inv=0.
- Reset mid-READ: RST_N low after 2 bytes → all EN low immediately; after release, requester 0 wins first and no stale invalidate is issued.
